// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: run-controller state encoding, instruction
// timing constants and the opcode map decoded by the control unit.
package sap1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PRIME  = 3'd2,
    ST_RUN    = 3'd3,
    ST_PAUSED = 3'd4,
    ST_HALTED = 3'd5
  } run_state_e;

  localparam int          T_STATES   = 6;
  localparam int          HLT_TSTATE = 3;
  localparam logic [3:0]  HLT_OPCODE = 4'b1111;

  localparam logic [3:0]  OP_LDA = 4'b0000;
  localparam logic [3:0]  OP_ADD = 4'b0100;
  localparam logic [3:0]  OP_SUB = 4'b0101;
  localparam logic [3:0]  OP_STA = 4'b0110;
  localparam logic [3:0]  OP_LDI = 4'b0111;
  localparam logic [3:0]  OP_JMP = 4'b1010;
  localparam logic [3:0]  OP_HLT = 4'b1111;

endpackage

// File: rtl/sap1_tstate_counter.sv
// Zero-based T-state counter that shadows the control unit's ring counter.
// Advances only while enabled, wraps after the last T-state, and flags the
// instruction boundary and the opcode-check T-state.
module sap1_tstate_counter
  import sap1_pkg::*;
#(
  parameter int NUM_STATES  = T_STATES,
  parameter int CHECK_STATE = HLT_TSTATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] tstate,
  output logic       at_boundary,
  output logic       at_check
);

  localparam logic [2:0] LAST_T  = 3'(NUM_STATES - 1);
  localparam logic [2:0] CHECK_T = 3'(CHECK_STATE);

  logic [2:0] tstate_q;
  logic [2:0] tstate_d;

  // Clear wins over enable; the count wraps to T1 after the last T-state.
  always_comb begin
    tstate_d = tstate_q;
    if (clr) begin
      tstate_d = '0;
    end else if (en) begin
      tstate_d = (tstate_q == LAST_T) ? 3'd0 : tstate_q + 3'd1;
    end
  end

  // T-state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tstate_q <= '0;
    end else begin
      tstate_q <= tstate_d;
    end
  end

  assign tstate      = tstate_q;
  assign at_boundary = (tstate_q == LAST_T);
  assign at_check    = (tstate_q == CHECK_T);

endmodule

// File: rtl/sap1_run_controller.sv
// SAP-1 run/program-mode sequencer. Loads program RAM over a valid/ready
// handshake, issues the start-of-program clear, and gates the control
// unit's clock enable for run, pause, single-step and halt.
module sap1_run_controller #(
  parameter int         ADDR_W     = 4,
  parameter int         DATA_W     = 8,
  parameter int         T_STATES   = sap1_pkg::T_STATES,
  parameter logic [3:0] HLT_OPCODE = sap1_pkg::HLT_OPCODE,
  parameter int         HLT_TSTATE = sap1_pkg::HLT_TSTATE
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              prog_mode,
  input  logic              start,
  input  logic              step,
  input  logic              pause,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [3:0]        opcode,
  output logic              cu_en,
  output logic              cu_clr,
  output logic [2:0]        tstate,
  output logic              halted,
  output logic              load_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  sap1_pkg::run_state_e state_q, state_d;

  logic              load_ready_q, load_ready_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cu_en_q, cu_en_d;
  logic              cu_clr_q, cu_clr_d;
  logic              halted_q, halted_d;
  logic              load_done_q, load_done_d;
  logic              pause_req_q, pause_req_d;
  logic              step_mode_q, step_mode_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              cnt_en;
  logic              cnt_clr;
  logic              at_boundary;
  logic              at_check;
  logic              accept;

  sap1_tstate_counter #(
    .NUM_STATES  (T_STATES),
    .CHECK_STATE (HLT_TSTATE)
  ) u_tstate (
    .clk         (CLK),
    .rst         (CLR),
    .en          (cnt_en),
    .clr         (cnt_clr),
    .tstate      (tstate),
    .at_boundary (at_boundary),
    .at_check    (at_check)
  );

  // Next-state and next-output decode; every output is derived from the
  // next state so it appears registered in the cycle the state takes effect.
  always_comb begin
    state_d     = state_q;
    pause_req_d = pause_req_q;
    step_mode_d = step_mode_q;
    wr_addr_d   = wr_addr_q;
    load_done_d = load_done_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    halted_d    = halted_q;
    cnt_en      = 1'b0;
    accept      = 1'b0;

    case (state_q)
      sap1_pkg::ST_IDLE: begin
        if (prog_mode) begin
          state_d = sap1_pkg::ST_LOAD;
        end else if (start) begin
          state_d     = sap1_pkg::ST_PRIME;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = sap1_pkg::ST_PRIME;
          step_mode_d = 1'b1;
        end
      end

      sap1_pkg::ST_LOAD: begin
        accept = load_valid & load_ready_q;
        if (accept) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = wr_addr_q;
          ram_wdata_d = load_data;
          wr_addr_d   = wr_addr_q + 1'b1;
        end
        if (accept && (wr_addr_q == LAST_ADDR)) begin
          load_done_d = 1'b1;
          state_d     = sap1_pkg::ST_IDLE;
        end else if (!prog_mode) begin
          state_d = sap1_pkg::ST_IDLE;
        end
      end

      sap1_pkg::ST_PRIME: begin
        state_d     = sap1_pkg::ST_RUN;
        pause_req_d = 1'b0;
      end

      sap1_pkg::ST_RUN: begin
        cnt_en = 1'b1;
        if (pause || prog_mode) begin
          pause_req_d = 1'b1;
        end
        if (at_check && (opcode == HLT_OPCODE)) begin
          cnt_en      = 1'b0;
          state_d     = sap1_pkg::ST_HALTED;
          pause_req_d = 1'b0;
          step_mode_d = 1'b0;
        end else if (at_boundary && (step_mode_q || pause_req_d)) begin
          state_d     = sap1_pkg::ST_PAUSED;
          pause_req_d = 1'b0;
          step_mode_d = 1'b0;
        end
      end

      sap1_pkg::ST_PAUSED: begin
        if (prog_mode) begin
          state_d = sap1_pkg::ST_LOAD;
        end else if (start) begin
          state_d     = sap1_pkg::ST_RUN;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = sap1_pkg::ST_RUN;
          step_mode_d = 1'b1;
        end
      end

      sap1_pkg::ST_HALTED: begin
        if (prog_mode) begin
          state_d = sap1_pkg::ST_LOAD;
        end else if (start) begin
          state_d     = sap1_pkg::ST_PRIME;
          step_mode_d = 1'b0;
        end
      end

      default: begin
        state_d = sap1_pkg::ST_IDLE;
      end
    endcase

    if ((state_d == sap1_pkg::ST_LOAD) && (state_q != sap1_pkg::ST_LOAD)) begin
      wr_addr_d   = '0;
      load_done_d = 1'b0;
      pause_req_d = 1'b0;
      step_mode_d = 1'b0;
    end

    if (state_d == sap1_pkg::ST_HALTED) begin
      halted_d = 1'b1;
    end else if (state_d == sap1_pkg::ST_PRIME) begin
      halted_d = 1'b0;
    end

    load_ready_d = (state_d == sap1_pkg::ST_LOAD);
    cu_en_d      = (state_d == sap1_pkg::ST_RUN);
    cu_clr_d     = (state_d == sap1_pkg::ST_PRIME);
    cnt_clr      = (state_d == sap1_pkg::ST_PRIME);
  end

  // State and registered outputs; CLR returns everything to IDLE.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q      <= sap1_pkg::ST_IDLE;
      load_ready_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cu_en_q      <= 1'b0;
      cu_clr_q     <= 1'b0;
      halted_q     <= 1'b0;
      load_done_q  <= 1'b0;
      pause_req_q  <= 1'b0;
      step_mode_q  <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= load_ready_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cu_en_q      <= cu_en_d;
      cu_clr_q     <= cu_clr_d;
      halted_q     <= halted_d;
      load_done_q  <= load_done_d;
      pause_req_q  <= pause_req_d;
      step_mode_q  <= step_mode_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  assign load_ready = load_ready_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign cu_en      = cu_en_q;
  assign cu_clr     = cu_clr_q;
  assign halted     = halted_q;
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_sap1_run_controller.sv
// Self-checking bench for sap1_run_controller: a reset/start table, then
// hand-written load, halt, pause, step, resume and priority sequences.
module tb_sap1_run_controller;
  import sap1_pkg::*;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       prog_mode = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       pause = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [3:0] opcode = 4'h0;
  logic       cu_en;
  logic       cu_clr;
  logic [2:0] tstate;
  logic       halted;
  logic       load_done;

  sap1_run_controller dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .prog_mode  (prog_mode),
    .start      (start),
    .step       (step),
    .pause      (pause),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .opcode     (opcode),
    .cu_en      (cu_en),
    .cu_clr     (cu_clr),
    .tstate     (tstate),
    .halted     (halted),
    .load_done  (load_done)
  );

  // Free-running 10-unit clock.
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       clr;
    logic       prog_mode;
    logic       start;
    logic       step;
    logic       pause;
    logic       load_valid;
    logic [7:0] load_data;
    logic [3:0] opcode;
  } in_t;

  typedef struct packed {
    logic       load_ready;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cu_en;
    logic       cu_clr;
    logic [2:0] tstate;
    logic       halted;
    logic       load_done;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  vec_t  vecs[$];
  out_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic in_t mkIn(logic c, logic pm, logic st, logic sp, logic pa,
                               logic v, logic [7:0] d, logic [3:0] op);
    in_t r;
    r = '{clr: c, prog_mode: pm, start: st, step: sp, pause: pa,
          load_valid: v, load_data: d, opcode: op};
    return r;
  endfunction

  function automatic out_t mkOut(logic rdy, logic we, logic [3:0] a, logic [7:0] wd,
                                 logic en, logic cl, logic [2:0] t, logic h, logic dn);
    out_t r;
    r = '{load_ready: rdy, ram_we: we, ram_addr: a, ram_wdata: wd, cu_en: en,
          cu_clr: cl, tstate: t, halted: h, load_done: dn};
    return r;
  endfunction

  function automatic string fmtOut(out_t o);
    return $sformatf("rdy=%0b we=%0b addr=%0h wd=%02h en=%0b clr=%0b t=%0d hlt=%0b done=%0b",
                     o.load_ready, o.ram_we, o.ram_addr, o.ram_wdata, o.cu_en,
                     o.cu_clr, o.tstate, o.halted, o.load_done);
  endfunction

  // Drive one cycle of inputs away from the rising edge and queue its expectation.
  task automatic applyStimulus(input in_t s, input out_t exp, input string tag);
    @(negedge CLK);
    CLR        = s.clr;
    prog_mode  = s.prog_mode;
    start      = s.start;
    step       = s.step;
    pause      = s.pause;
    load_valid = s.load_valid;
    load_data  = s.load_data;
    opcode     = s.opcode;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Sample just after the rising edge and compare with the oldest expectation.
  task automatic checkOutput();
    out_t  got;
    out_t  want;
    string tag;
    @(posedge CLK);
    #1;
    got = '{load_ready: load_ready, ram_we: ram_we, ram_addr: ram_addr,
            ram_wdata: ram_wdata, cu_en: cu_en, cu_clr: cu_clr, tstate: tstate,
            halted: halted, load_done: load_done};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got %s, expected a queued entry", fmtOut(got));
    end else begin
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL %s: got %s, expected %s", tag, fmtOut(got), fmtOut(want));
      end
    end
  endtask

  task automatic cycle(input in_t s, input out_t exp, input string tag);
    applyStimulus(s, exp, tag);
    checkOutput();
  endtask

  initial begin
    in_t  s;
    out_t e;
    int   b;
    int   c;

    // Reset, ignored pause in IDLE, start latency, T-state wrap, reset mid-RUN.
    vecs.push_back('{mkIn(1,0,0,0,0,0,8'h00,4'h0), mkOut(0,0,4'h0,8'h00,0,0,3'd0,0,0)});
    vecs.push_back('{mkIn(1,0,0,0,0,0,8'h00,4'h0), mkOut(0,0,4'h0,8'h00,0,0,3'd0,0,0)});
    vecs.push_back('{mkIn(0,0,0,0,1,0,8'h00,4'h0), mkOut(0,0,4'h0,8'h00,0,0,3'd0,0,0)});
    vecs.push_back('{mkIn(0,0,1,0,0,0,8'h00,4'h0), mkOut(0,0,4'h0,8'h00,0,1,3'd0,0,0)});
    for (int k = 0; k < 9; k++) begin
      vecs.push_back('{mkIn(0,0,0,0,0,0,8'h00,4'h0),
                       mkOut(0,0,4'h0,8'h00,1,0,3'(k % 6),0,0)});
    end
    vecs.push_back('{mkIn(1,0,0,0,0,0,8'h00,4'h0), mkOut(0,0,4'h0,8'h00,0,0,3'd0,0,0)});
    vecs.push_back('{mkIn(0,0,0,0,0,0,8'h00,4'h0), mkOut(0,0,4'h0,8'h00,0,0,3'd0,0,0)});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim, vecs[i].exp, $sformatf("vec%0d", i));
      checkOutput();
    end
    $display("[TB] table vectors applied: %0d", vecs.size());

    // Program load: 16 bytes with load_valid low every third cycle.
    e = '0;
    s = '0; s.prog_mode = 1'b1;
    e.load_ready = 1'b1;
    cycle(s, e, "load_entry");
    b = 0;
    c = 0;
    while (b < 16) begin
      s = '0;
      s.prog_mode  = 1'b1;
      s.load_valid = ((c % 3) != 2);
      s.load_data  = s.load_valid ? (8'h10 + 8'(b)) : 8'hEE;
      if (s.load_valid) begin
        e.ram_we     = 1'b1;
        e.ram_addr   = 4'(b);
        e.ram_wdata  = 8'h10 + 8'(b);
        e.load_ready = (b != 15);
        e.load_done  = (b == 15);
        b++;
      end else begin
        e.ram_we = 1'b0;
      end
      cycle(s, e, $sformatf("load_c%0d", c));
      c++;
    end
    for (int k = 0; k < 3; k++) begin
      s = '0; s.load_valid = 1'b1; s.load_data = 8'hAA;
      e.ram_we = 1'b0; e.load_ready = 1'b0;
      cycle(s, e, $sformatf("load_post%0d", k));
    end

    // Start, then HLT at T4 together with a pause request.
    s = '0; s.start = 1'b1;
    e.cu_clr = 1'b1; e.cu_en = 1'b0; e.tstate = 3'd0;
    cycle(s, e, "start_prime");
    s = '0;
    e.cu_clr = 1'b0; e.cu_en = 1'b1; e.tstate = 3'd0;
    cycle(s, e, "start_t0");
    e.tstate = 3'd1;
    cycle(s, e, "start_t1");
    s.opcode = OP_HLT;
    e.tstate = 3'd2;
    cycle(s, e, "hlt_early_t1");
    e.tstate = 3'd3;
    cycle(s, e, "hlt_early_t2");
    s.pause = 1'b1;
    e.cu_en = 1'b0; e.halted = 1'b1;
    cycle(s, e, "hlt_taken");
    s = '0; s.opcode = OP_HLT; s.step = 1'b1;
    cycle(s, e, "halted_step_ignored");
    s.step = 1'b0;
    cycle(s, e, "halted_hold");

    // Restart from HALTED clears halted and the T-state.
    s = '0; s.start = 1'b1;
    e.cu_clr = 1'b1; e.halted = 1'b0; e.tstate = 3'd0;
    cycle(s, e, "restart_prime");
    s = '0; s.opcode = OP_ADD;
    e.cu_clr = 1'b0; e.cu_en = 1'b1;
    cycle(s, e, "restart_t0");

    // Pause requested during T2 takes effect at the instruction boundary.
    for (int k = 1; k <= 5; k++) begin
      s = '0; s.opcode = OP_ADD; s.pause = (k == 2);
      e.tstate = 3'(k);
      cycle(s, e, $sformatf("pause_t%0d", k));
    end
    s = '0;
    e.cu_en = 1'b0; e.tstate = 3'd0;
    cycle(s, e, "pause_stop");
    s.pause = 1'b1;
    cycle(s, e, "paused_pause_ignored");

    // Single step runs exactly one instruction.
    s = '0; s.step = 1'b1;
    e.cu_en = 1'b1; e.tstate = 3'd0;
    cycle(s, e, "step_t0");
    for (int k = 1; k <= 5; k++) begin
      s = '0; e.tstate = 3'(k);
      cycle(s, e, $sformatf("step_t%0d", k));
    end
    s = '0;
    e.cu_en = 1'b0; e.tstate = 3'd0;
    cycle(s, e, "step_stop");

    // Resume from PAUSED without a clear, then pause again.
    s = '0; s.start = 1'b1;
    e.cu_en = 1'b1; e.cu_clr = 1'b0; e.tstate = 3'd0;
    cycle(s, e, "resume_t0");
    for (int k = 1; k <= 5; k++) begin
      s = '0; s.pause = (k == 1);
      e.tstate = 3'(k);
      cycle(s, e, $sformatf("resume_t%0d", k));
    end
    s = '0;
    e.cu_en = 1'b0; e.tstate = 3'd0;
    cycle(s, e, "resume_stop");

    // prog_mode beats start in PAUSED; dropping it aborts the load.
    s = '0; s.prog_mode = 1'b1; s.start = 1'b1;
    e.load_ready = 1'b1; e.load_done = 1'b0; e.cu_clr = 1'b0;
    cycle(s, e, "prio_load");
    s = '0;
    e.load_ready = 1'b0;
    cycle(s, e, "load_abort");
    cycle(s, e, "load_abort_idle");

    // step from IDLE primes and runs one instruction.
    s = '0; s.step = 1'b1;
    e.cu_clr = 1'b1;
    cycle(s, e, "idle_step_prime");
    for (int k = 0; k <= 5; k++) begin
      s = '0;
      e.cu_clr = 1'b0; e.cu_en = 1'b1; e.tstate = 3'(k);
      cycle(s, e, $sformatf("idle_step_t%0d", k));
    end
    s = '0;
    e.cu_en = 1'b0; e.tstate = 3'd0;
    cycle(s, e, "idle_step_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap1_run_controller.md
Name: sap1_run_controller

Overview:
Run/program-mode sequencer for the SAP-1 core. It sits between the front panel and the unidadeDeControle/datapath, and decides when the control unit's T-state ring advances.
- Loads program bytes into the 16x8 RAM through a valid/ready handshake.
- Issues the start-of-program clear.
- Gates the control unit's clock enable for run, pause and single-instruction step.
- Stops the machine on HLT.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
DATA_W, 8, RAM word width.
T_STATES, 6, T-states per instruction (T1..T6).
HLT_OPCODE, 4'b1111, opcode that halts execution.
HLT_TSTATE, 3, zero-based T-state at which opcode is valid and checked (T4).

Ports:
CLK  in  1  system clock, all logic on rising edge.
CLR  in  1  synchronous active-high reset.
prog_mode  in  1  level: request program-load mode.
start  in  1  pulse: start from address 0 or resume.
step  in  1  pulse: execute exactly one instruction.
pause  in  1  pulse: stop at the next instruction boundary.
load_valid  in  1  load byte present.
load_data  in  DATA_W  load byte.
load_ready  out  1  controller accepts a byte this cycle.
ram_we  out  1  RAM write strobe.
ram_addr  out  ADDR_W  RAM write address.
ram_wdata  out  DATA_W  RAM write data.
opcode  in  4  IR upper nibble from the datapath.
cu_en  out  1  clock enable to control unit and datapath registers.
cu_clr  out  1  one-cycle clear of PC, IR and ring counter.
tstate  out  3  controller's T-state count, zero-based, in lockstep with the ring.
halted  out  1  HLT executed.
load_done  out  1  all 2**ADDR_W words written since the last LOAD entry.

Behaviour:
- Reset: on CLR=1 at a clock edge, the block enters IDLE.
  - load_ready, ram_we, cu_en, cu_clr, halted, load_done = 0.
  - ram_addr, ram_wdata, tstate = 0.
  - pause_req and step_mode flags cleared.
  - CLR overrides everything, including mid-load and mid-instruction.
- All outputs are Moore/registered. There is no combinational path from inputs to outputs.
- States: IDLE, LOAD, PRIME, RUN, PAUSED, HALTED.
- Input priority in IDLE, PAUSED and HALTED: prog_mode > start > step.
- IDLE:
  - prog_mode -> LOAD.
  - start -> PRIME with step_mode=0.
  - step -> PRIME with step_mode=1.
- LOAD:
  - Entry sets the write address to 0 and clears load_done; load_ready=1 while in LOAD.
  - Handshake on load_valid & load_ready. On the next cycle: ram_we=1 for 1 cycle, ram_addr = current address, ram_wdata = the byte; the address then increments.
  - After the write to address 2**ADDR_W-1, load_done=1, load_ready drops, and the state goes to IDLE. The address wraps to 0 and no extra write occurs.
  - If prog_mode falls mid-load, go to IDLE with load_done=0. The partial contents stay in RAM.
- PRIME: cu_clr=1 for exactly 1 cycle, cu_en=0, tstate<=0, halted<=0; next state RUN.
- RUN:
  - cu_en=1 every cycle. tstate increments each cycle and wraps from T_STATES-1 to 0.
  - pause or prog_mode sets pause_req (sticky).
  - HLT check: at tstate==HLT_TSTATE with opcode==HLT_OPCODE, go to HALTED. cu_en=0 from the next cycle; halted=1; tstate is held. This has priority over pause_req and step_mode.
  - Boundary: at tstate==T_STATES-1, if step_mode or pause_req, go to PAUSED. tstate wraps to 0, and pause_req and step_mode clear.
- PAUSED: cu_en=0, tstate=0.
  - start -> RUN with step_mode=0 (resume, no cu_clr).
  - step -> RUN with step_mode=1.
  - prog_mode -> LOAD.
- HALTED: cu_en=0, halted=1.
  - start -> PRIME (restart from address 0).
  - prog_mode -> LOAD; halted stays 1 until the next PRIME.
  - step is ignored.
- start, step and pause arriving in states that do not use them are ignored, not queued. The exception is pause/prog_mode in RUN, which latch into pause_req.
- Latency:
  - start in IDLE: cu_en rises 2 cycles later (PRIME, then RUN).
  - start in PAUSED: cu_en rises 1 cycle later.

Decomposition:
- Shared package sap1_pkg:
  - State enum encoding.
  - T_STATES, HLT_OPCODE.
  - The opcode constants already used by the control unit (ADD 0100 through JMP 1010, HLT 1111).
- Natural sub-module: sap1_tstate_counter (enable, clear, wrap at T_STATES-1, boundary and check-state flags).
- Load handshake and FSM remain in the top module.

Test Plan:
- Reset mid-RUN at tstate=2: CLR for 1 cycle -> the next cycle shows IDLE, cu_en=0, tstate=0, halted=0.
- Load: prog_mode=1, 16 bytes 0x10..0x1F with load_valid gapped every third cycle -> ram_we pulses 16 times, addr 0..15 in order, data matches, load_done=1, state IDLE, no write after addr 15.
- Start: start pulse in IDLE -> cu_clr=1 exactly 1 cycle, cu_en=1 from the following cycle, tstate sequence 0,1,2,3,4,5,0.
- Halt: opcode=4'b1111 in RUN -> at tstate 3 the state goes HALTED; cu_en=0 the next cycle, halted=1, tstate holds 3. A later start pulse -> PRIME and halted clears.
- Pause and step: pause at tstate 1 -> cu_en stays 1 through tstate 5, then PAUSED. step -> exactly 6 cu_en cycles, then PAUSED. start -> resume without cu_clr.
- Priority: prog_mode=1 and start in the same cycle in PAUSED -> LOAD is entered and no cu_clr is issued. pause and HLT together at tstate 3 -> HALTED.
